// File: rtl/branch_pkg.sv
// Shared types for the branch resolve stage: funct3 codes,
// result bundle, skid-buffer states and the sequential PC step.
package branch_pkg;

  localparam int          BR_XLEN = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } funct3_e;

  typedef struct packed {
    logic               taken;
    logic               illegal;
    logic [BR_XLEN-1:0] next_pc;
    logic [BR_XLEN-1:0] target;
  } br_result_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/br_skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready/out_valid.
// Ports: clk, reset_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module br_skid_buf
  import branch_pkg::*;
#(
  parameter type T = br_result_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  skid_state_e state;
  T            spare;
  logic        in_fire;
  logic        out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // out_data is the head entry; spare holds the younger entry in TWO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      spare     <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            spare    <= in_data;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (!in_fire && out_fire) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (in_fire && out_fire) begin
            out_data <= in_data;
          end
        end
        TWO: begin
          if (out_fire) begin
            out_data <= spare;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/comparatortree32.sv
// 32-bit operand comparator: equality, signed and unsigned less-than.
// Ports: a, b operands; eq, lt (signed), ltu (unsigned) results.
module comparatortree32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign ltu = (a < b);
  assign lt  = ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: compares operands, decodes funct3 into
// taken/illegal, computes target and next PC, and registers the result
// through a 2-entry skid buffer.
// Ports: clk, reset_n; in_valid/in_ready, in_op1, in_op2, in_funct3,
// in_pc, in_imm; out_valid/out_ready, out_taken, out_illegal,
// out_next_pc, out_target.
// Optional BRANCH_PERF_EN adds perf_taken_cnt, perf_nottaken_cnt and
// perf_illegal_cnt, counting output transfers by outcome.
// XLEN must stay 32: the comparator is fixed-width.
module branch_resolve_stage #(
  parameter int          XLEN   = 32,
  parameter logic [31:0] PC_INC = branch_pkg::PC_INC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_next_pc,
  output logic [XLEN-1:0] out_target
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_taken_cnt,
  output logic [31:0]     perf_nottaken_cnt,
  output logic [31:0]     perf_illegal_cnt
`endif
);

  import branch_pkg::*;

  logic       eq;
  logic       lt;
  logic       ltu;
  br_result_t res;
  br_result_t head;

  comparatortree32 u_cmp (
    .a   (in_op1),
    .b   (in_op2),
    .eq  (eq),
    .lt  (lt),
    .ltu (ltu)
  );

  always_comb begin
    res         = '0;
    res.target  = in_pc + in_imm;
    unique case (1'b1)
      (in_funct3 == BEQ):  res.taken = eq;
      (in_funct3 == BNE):  res.taken = ~eq;
      (in_funct3 == BLT):  res.taken = lt;
      (in_funct3 == BGE):  res.taken = ~lt;
      (in_funct3 == BLTU): res.taken = ltu;
      (in_funct3 == BGEU): res.taken = ~ltu;
      default:             res.illegal = 1'b1;
    endcase
    res.next_pc = res.taken ? res.target : in_pc + PC_INC;
  end

  br_skid_buf #(
    .T (br_result_t)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_taken   = head.taken;
  assign out_illegal = head.illegal;
  assign out_next_pc = head.next_pc;
  assign out_target  = head.target;

`ifdef BRANCH_PERF_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_taken_cnt    <= '0;
      perf_nottaken_cnt <= '0;
      perf_illegal_cnt  <= '0;
    end else if (out_fire) begin
      unique case (1'b1)
        head.illegal: perf_illegal_cnt  <= perf_illegal_cnt + 32'd1;
        head.taken:   perf_taken_cnt    <= perf_taken_cnt + 32'd1;
        default:      perf_nottaken_cnt <= perf_nottaken_cnt + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Scoreboard bench for branch_resolve_stage: directed plan cases,
// backpressure, mid-run reset and randomized traffic.
module tb_branch_resolve_stage;

  typedef struct {
    logic        taken;
    logic        illegal;
    logic [31:0] next_pc;
    logic [31:0] target;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_taken;
  logic        out_illegal;
  logic [31:0] out_next_pc;
  logic [31:0] out_target;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_taken_cnt;
  logic [31:0] perf_nottaken_cnt;
  logic [31:0] perf_illegal_cnt;
`endif

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  bit   rand_bp = 0;
  int   n_taken = 0;
  int   n_nott = 0;
  int   n_ill = 0;

  branch_resolve_stage dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_funct3   (in_funct3),
    .in_pc       (in_pc),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_taken   (out_taken),
    .out_illegal (out_illegal),
    .out_next_pc (out_next_pc),
    .out_target  (out_target)
`ifdef BRANCH_PERF_EN
    ,
    .perf_taken_cnt    (perf_taken_cnt),
    .perf_nottaken_cnt (perf_nottaken_cnt),
    .perf_illegal_cnt  (perf_illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input logic [31:0] pc,
                                 input logic [31:0] imm);
    exp_t e;
    e.taken   = 1'b0;
    e.illegal = 1'b0;
    case (f)
      3'd0: e.taken = (a == b);
      3'd1: e.taken = (a != b);
      3'd4: e.taken = ($signed(a) < $signed(b));
      3'd5: e.taken = ($signed(a) >= $signed(b));
      3'd6: e.taken = (a < b);
      3'd7: e.taken = (a >= b);
      default: e.illegal = 1'b1;
    endcase
    e.target  = pc + imm;
    e.next_pc = e.taken ? pc + imm : pc + 32'd4;
    return e;
  endfunction

  task automatic check(input string name, input logic [97:0] act,
                       input logic [97:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: checks head on every presented output, then records new
  // input transfers as expected results.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual=valid required=none");
        end else begin
          check(out_ready ? "result" : "hold",
                {out_taken, out_illegal, out_next_pc, out_target},
                {q[0].taken, q[0].illegal, q[0].next_pc, q[0].target});
          if (out_ready) begin
            if (q[0].illegal) n_ill++;
            else if (q[0].taken) n_taken++;
            else n_nott++;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(in_op1, in_op2, in_funct3, in_pc, in_imm));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, input logic [31:0] pc,
                      input logic [31:0] imm);
    int n;
    n = 0;
    in_op1 = a;
    in_op2 = b;
    in_funct3 = f;
    in_pc = pc;
    in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic t,
                            input logic il, input logic [31:0] np,
                            input logic [31:0] tg);
    @(negedge clk);
    check(name, {out_valid, out_taken, out_illegal, out_next_pc, out_target},
          {1'b1, t, il, np, tg});
  endtask

  task automatic drain;
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", {66'd0, q.size()}, 98'd0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {out_valid, in_ready, out_taken, out_illegal, out_next_pc, out_target},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h1234, 32'h1234, 3'b000, 32'h100, 32'h20);
    expect_now("beq_equal", 1'b1, 1'b0, 32'h120, 32'h120);
    @(posedge clk); #1;
    send(32'hFFFF_FFFF, 32'h1, 3'b100, 32'h200, 32'h40);
    expect_now("blt_signed", 1'b1, 1'b0, 32'h240, 32'h240);
    @(posedge clk); #1;
    send(32'hFFFF_FFFF, 32'h1, 3'b110, 32'h200, 32'h40);
    expect_now("bltu_unsigned", 1'b0, 1'b0, 32'h204, 32'h240);
    @(posedge clk); #1;
    send(32'h5, 32'h5, 3'b010, 32'h300, 32'h10);
    expect_now("illegal_010", 1'b0, 1'b1, 32'h304, 32'h310);
    @(posedge clk); #1;
    send(32'h7, 32'h7, 3'b000, 32'hFFFF_FFFC, 32'h8);
    expect_now("wrap_taken", 1'b1, 1'b0, 32'h4, 32'h4);
    @(posedge clk); #1;
    send(32'h7, 32'h8, 3'b000, 32'hFFFF_FFFC, 32'h8);
    expect_now("wrap_nottaken", 1'b0, 1'b0, 32'h0, 32'h4);
    @(posedge clk); #1;
    drain();

    // Backpressure: two accepted, third stalls until downstream drains.
    out_ready = 1'b0;
    send(32'h1, 32'h2, 3'b001, 32'h1000, 32'h10);
    send(32'h3, 32'h3, 3'b000, 32'h2000, 32'h20);
    in_op1 = 32'h9;
    in_op2 = 32'h4;
    in_funct3 = 3'b111;
    in_pc = 32'h3000;
    in_imm = 32'h30;
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", {97'd0, in_ready}, 98'd0);
    check("bp_queue_depth", {66'd0, q.size()}, 98'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h9, 32'h4, 3'b111, 32'h3000, 32'h30);
    drain();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    send(32'h1, 32'h1, 3'b000, 32'h40, 32'h8);
    send(32'h2, 32'h1, 3'b000, 32'h50, 32'h8);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs",
          {out_valid, in_ready, out_taken, out_illegal, out_next_pc, out_target},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    q.delete();
    n_taken = 0;
    n_nott = 0;
    n_ill = 0;
`ifdef BRANCH_PERF_EN
    check("perf_reset", {2'd0, perf_taken_cnt, perf_nottaken_cnt, perf_illegal_cnt},
          98'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h6, 32'h6, 3'b000, 32'h80, 32'h4);
    send(32'h6, 32'h6, 3'b001, 32'h90, 32'h4);
    send(32'h6, 32'h6, 3'b011, 32'hA0, 32'h4);
    drain();
`ifdef BRANCH_PERF_EN
    check("perf_one_each", {2'd0, perf_taken_cnt, perf_nottaken_cnt, perf_illegal_cnt},
          {2'd0, 32'd1, 32'd1, 32'd1});
`endif

    // Randomized traffic with random downstream stalls.
    rand_bp = 1;
    cnt = 0;
    while (cnt < 400) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(a, b, 3'($urandom_range(0, 7)), $urandom, $urandom);
      cnt++;
    end
    rand_bp = 0;
    #1;
    drain();
`ifdef BRANCH_PERF_EN
    check("perf_totals", {2'd0, perf_taken_cnt, perf_nottaken_cnt, perf_illegal_cnt},
          {2'd0, 32'(n_taken), 32'(n_nott), 32'(n_ill)});
`endif
    check("final_idle", {96'd0, out_valid, in_ready}, {96'd0, 1'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
